// File: rtl/tt_cnt_pkg.sv
// Shared types and helpers for the tt_param_counter tile.
package tt_cnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Saturate a value to the terminal value; callers size to their own width.
  function automatic logic [15:0] clamp_val(input logic [15:0] val, input logic [15:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/tt_cnt_prescaler.sv
// Tick generator: one tick every div_i+1 enabled RUN cycles.
// Only instantiated when CNT_PRESCALE_EN is defined.
module tt_cnt_prescaler #(
  parameter int unsigned PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               run_i,
  input  logic               en_i,
  input  logic [PRESC_W-1:0] div_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] presc_q;

  assign tick_o = run_i && en_i && (presc_q == div_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (clr_i || tick_o) begin
      presc_q <= '0;
    end else if (run_i && en_i) begin
      presc_q <= presc_q + 1'b1;
    end
  end

endmodule

// File: rtl/tt_param_counter.sv
// Parametrised up/down counter/timer with IDLE/RUN/DONE run control.
// Optional prescaler and presc_div port are enabled by defining CNT_PRESCALE_EN.
module tt_param_counter
  import tt_cnt_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = 2**WIDTH - 1,
  parameter int unsigned PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               start,
  input  logic               stop,
  input  logic               en,
  input  logic               dir,
  input  logic               oneshot,
  input  logic               out_en,
`ifdef CNT_PRESCALE_EN
  input  logic [PRESC_W-1:0] presc_div,
`endif
  output logic [WIDTH-1:0]   count,
  output logic [WIDTH-1:0]   data_out,
  output logic               data_oe,
  output logic               tc,
  output logic               ovf,
  output logic               busy
);

  if (WIDTH < 2 || WIDTH > 16 || MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1 || PRESC_W < 1)
  begin : g_param_check
    $error("tt_param_counter: unsupported parameter combination");
  end

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic             tc_q;
  logic             ovf_q;

  logic             tick;
  logic             step;
  logic             stop_fire;
  logic             start_fire;
  logic [15:0]      load_clamp16;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_step;
  logic             wrap;
  logic             hit_term;

  assign load_clamp16 = clamp_val(16'(load_val), 16'(MAX_VAL));
  assign load_clamped = load_clamp16[WIDTH-1:0];

  // stop beats start; start is a no-op while already running.
  assign stop_fire  = stop && (state_q == RUN);
  assign start_fire = start && !stop && (state_q != RUN);

`ifdef CNT_PRESCALE_EN
  tt_cnt_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr || load || start_fire),
    .run_i  (state_q == RUN),
    .en_i   (en),
    .div_i  (presc_div),
    .tick_o (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign step = (state_q == RUN) && en && tick;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    wrap       = 1'b0;
    count_step = count_q;
    if (dir == DIR_UP) begin
      wrap       = (count_q == MAX_C);
      count_step = wrap ? '0 : count_q + 1'b1;
    end else begin
      wrap       = (count_q == '0);
      count_step = wrap ? MAX_C : count_q - 1'b1;
    end
    hit_term = oneshot && (count_step == ((dir == DIR_UP) ? MAX_C : '0));
  end

  // NOTE: sequential state uses non-blocking (<=) so all registers update
  // together from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (clr) begin
        state_q <= IDLE;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else if (load) begin
        count_q <= load_clamped;
      end else if (stop_fire) begin
        state_q <= IDLE;
      end else if (start_fire) begin
        state_q <= RUN;
        if (state_q == DONE) begin
          count_q <= (dir == DIR_UP) ? '0 : MAX_C;
        end
      end else if (step) begin
        count_q <= count_step;
        if (wrap) begin
          ovf_q <= 1'b1;
        end
        // One-shot pulses only on reaching the terminal; periodic on every wrap.
        tc_q <= oneshot ? hit_term : wrap;
        if (hit_term) begin
          state_q <= DONE;
        end
      end
    end
  end

  assign count    = count_q;
  assign data_out = out_en ? count_q : '0;
  assign data_oe  = out_en;
  assign tc       = tc_q;
  assign ovf      = ovf_q;
  assign busy     = (state_q == RUN);

endmodule

// File: tb/tb_tt_param_counter.sv
// Self-checking bench for tt_param_counter (WIDTH=8, MAX_VAL=9): directed
// scenarios plus randomized traffic against a behavioural model.
module tb_tt_param_counter;

  localparam int WIDTH   = 8;
  localparam int MAX_VAL = 9;
  localparam int PRESC_W = 4;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             clr      = 1'b0;
  logic             load     = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             start    = 1'b0;
  logic             stop     = 1'b0;
  logic             en       = 1'b0;
  logic             dir      = 1'b1;
  logic             oneshot  = 1'b0;
  logic             out_en   = 1'b1;
`ifdef CNT_PRESCALE_EN
  logic [PRESC_W-1:0] presc_div = 4'd2;
`endif
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] data_out;
  logic             data_oe;
  logic             tc;
  logic             ovf;
  logic             busy;

  int n_chk = 0;
  int n_err = 0;

  tt_param_counter #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .en       (en),
    .dir      (dir),
    .oneshot  (oneshot),
    .out_en   (out_en),
`ifdef CNT_PRESCALE_EN
    .presc_div(presc_div),
`endif
    .count    (count),
    .data_out (data_out),
    .data_oe  (data_oe),
    .tc       (tc),
    .ovf      (ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: mode plus count kept as plain integers, stepped mod MAX_VAL+1.
  typedef enum {M_IDLE, M_RUN, M_DONE} mmode_t;
  mmode_t m_mode = M_IDLE;
  int     m_cnt  = 0;
  int     m_presc = 0;
  bit     m_tc   = 0;
  bit     m_ovf  = 0;

  task automatic model_edge();
    int nxt;
    bit wrapped;
    bit tick;
    if (!rst_n) begin
      m_mode = M_IDLE; m_cnt = 0; m_tc = 0; m_ovf = 0; m_presc = 0;
      return;
    end
    m_tc = 0;
    if (clr) begin
      m_mode = M_IDLE; m_cnt = 0; m_ovf = 0; m_presc = 0;
    end else if (load) begin
      m_cnt   = (int'(load_val) > MAX_VAL) ? MAX_VAL : int'(load_val);
      m_presc = 0;
    end else if (stop && m_mode == M_RUN) begin
      m_mode = M_IDLE;
    end else if (start && !stop && m_mode != M_RUN) begin
      if (m_mode == M_DONE) m_cnt = dir ? 0 : MAX_VAL;
      m_mode  = M_RUN;
      m_presc = 0;
    end else if (m_mode == M_RUN && en) begin
      tick = 1;
`ifdef CNT_PRESCALE_EN
      if (m_presc == int'(presc_div)) m_presc = 0;
      else begin
        m_presc = (m_presc + 1) % (1 << PRESC_W);
        tick = 0;
      end
`endif
      if (tick) begin
        // Adding MAX_VAL modulo MAX_VAL+1 is a decrement.
        nxt     = (m_cnt + (dir ? 1 : MAX_VAL)) % (MAX_VAL + 1);
        wrapped = dir ? (nxt == 0) : (nxt == MAX_VAL);
        if (wrapped) m_ovf = 1;
        if (oneshot) begin
          if (nxt == (dir ? MAX_VAL : 0)) begin
            m_tc = 1;
            m_mode = M_DONE;
          end
        end else begin
          m_tc = wrapped;
        end
        m_cnt = nxt;
      end
    end
  endtask

  always @(posedge clk) begin
    model_edge();
    #1;
    check("m_count",    count,    m_cnt);
    check("m_tc",       tc,       m_tc);
    check("m_ovf",      ovf,      m_ovf);
    check("m_busy",     busy,     m_mode == M_RUN);
    check("m_data_out", data_out, out_en ? m_cnt : 0);
    check("m_data_oe",  data_oe,  out_en);
  end

  task automatic nedge();
    @(negedge clk);
  endtask

  initial begin
    repeat (2) nedge();
    check("rst_count", count, 0);
    check("rst_tc",    tc,    0);
    check("rst_ovf",   ovf,   0);
    check("rst_busy",  busy,  0);
    rst_n = 1'b1;
    nedge();

`ifndef CNT_PRESCALE_EN
    // Periodic up from 0: 1..9 then wrap to 0 with a single tc.
    oneshot = 0; dir = 1; en = 1; start = 1;
    nedge();
    start = 0;
    check("t1_start_count", count, 0);
    for (int i = 1; i <= 10; i++) begin
      nedge();
      check("t1_count", count, i % 10);
      check("t1_tc",    tc,    i == 10);
    end
    check("t1_ovf", ovf, 1);
    stop = 1;
    nedge();
    stop = 0;
    check("t1_stop_busy",  busy,  0);
    check("t1_stop_count", count, 0);

    // One-shot down from 3.
    clr = 1;
    nedge();
    clr = 0;
    check("t2_clr_ovf", ovf, 0);
    load = 1; load_val = 8'd3;
    nedge();
    load = 0;
    check("t2_load", count, 3);
    dir = 0; oneshot = 1; start = 1;
    nedge();
    start = 0;
    check("t2_busy", busy, 1);
    for (int i = 1; i <= 3; i++) begin
      nedge();
      check("t2_count", count, 3 - i);
      check("t2_tc",    tc,    i == 3);
    end
    check("t2_done_busy", busy, 0);
    nedge();
    check("t2_hold_count", count, 0);
    check("t2_hold_tc",    tc,    0);

    // Clamped load, restart from DONE, load during RUN suppresses the step.
    load = 1; load_val = 8'd200;
    nedge();
    load = 0;
    check("t3_clamp", count, 9);
    check("t3_clamp_busy", busy, 0);
    dir = 1; oneshot = 0; start = 1;
    nedge();
    start = 0;
    check("t3_restart_count", count, 0);
    check("t3_restart_busy",  busy,  1);
    nedge();
    nedge();
    check("t3_pre_load", count, 2);
    load = 1; load_val = 8'd4;
    nedge();
    load = 0;
    check("t3_load_run", count, 4);
    check("t3_load_tc",  tc,    0);
    repeat (3) nedge();
    check("t3_count7", count, 7);

    // Output gate follows out_en combinationally.
    en = 0;
    out_en = 0;
    #1;
    check("t5_gate_off_data", data_out, 0);
    check("t5_gate_off_oe",   data_oe,  0);
    out_en = 1;
    #1;
    check("t5_gate_on_data", data_out, 7);
    check("t5_gate_on_oe",   data_oe,  1);
    nedge();
    check("t5_hold", count, 7);

    // Async reset mid-run with ovf set and count 5.
    load = 1; load_val = 8'd9;
    nedge();
    load = 0; en = 1;
    nedge();
    check("t4_wrap_tc",  tc,  1);
    check("t4_wrap_ovf", ovf, 1);
    load = 1; load_val = 8'd5; en = 0;
    nedge();
    load = 0;
    check("t4_pre_count", count, 5);
    rst_n = 0;
    #1;
    check("t4_rst_count", count, 0);
    check("t4_rst_tc",    tc,    0);
    check("t4_rst_ovf",   ovf,   0);
    check("t4_rst_busy",  busy,  0);
    nedge();
    rst_n = 1; start = 1; en = 1;
    nedge();
    start = 0;
    check("t4_restart", count, 0);
    nedge();
    check("t4_first_step", count, 1);
`else
    // Prescaler: divide by 3, and en low for two cycles stretches by two.
    presc_div = 4'd2; oneshot = 0; dir = 1; en = 1; start = 1;
    nedge();
    start = 0;
    for (int i = 1; i <= 3; i++) begin
      nedge();
      check("t6_count_a", count, (i == 3) ? 1 : 0);
    end
    en = 0;
    repeat (2) nedge();
    check("t6_hold", count, 1);
    en = 1;
    for (int i = 1; i <= 3; i++) begin
      nedge();
      check("t6_count_b", count, (i == 3) ? 2 : 1);
    end
`endif

    // Randomized traffic, checked every cycle against the model.
    clr = 1;
    nedge();
    clr = 0;
    for (int i = 0; i < 800; i++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      clr      = ($urandom_range(0, 99) < 3);
      load     = ($urandom_range(0, 99) < 8);
      load_val = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(10, 255))
                                             : 8'($urandom_range(0, 9));
      start    = ($urandom_range(0, 99) < 12);
      stop     = ($urandom_range(0, 99) < 6);
      en       = ($urandom_range(0, 99) < 80);
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      if ($urandom_range(0, 29) == 0) oneshot = ~oneshot;
      out_en   = ($urandom_range(0, 3) != 0);
`ifdef CNT_PRESCALE_EN
      if ($urandom_range(0, 49) == 0) presc_div = 4'($urandom_range(0, 3));
`endif
      nedge();
    end
    rst_n = 1; clr = 0; load = 0; start = 0; stop = 0;
    nedge();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
